// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative 64-bit multiply / divide unit with one bit processed per cycle.
//
//   Multiply : 128-bit product. Low half goes to data_1_o and high half to
//              data_2_o. Signed, unsigned and mixed-sign operands are
//              selected by rs1_sign_i / rs2_sign_i.
//   Divide   : quotient goes to data_1_o and remainder to data_2_o, using
//              restoring division. The quotient is truncated toward zero
//              and the remainder takes the sign of the dividend.
//              Divide by zero completes one cycle after accept with
//              quotient = all ones and remainder = dividend.
//
// Timing after the accept edge:
//   - 1 prep cycle, in which the operands are converted to magnitudes.
//   - 64 CALC iterations.
//   - 1 DONE cycle, in which resp_valid_o is high.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   rs1_data_i   : operand A (multiplicand / dividend)
//   rs2_data_i   : operand B (multiplier / divisor)
//   rs1_sign_i   : operand A is signed
//   rs2_sign_i   : operand B is signed
//   req_valid_i  : request present (sampled only in IDLE)
//   mul_en_i     : 1 = multiply, 0 = divide
//   flush_i      : abort; returns to IDLE with no response
//   ready_o      : unit is idle and will accept a request
//   resp_valid_o : single-cycle result strobe
//   data_1_o     : product low half / quotient
//   data_2_o     : product high half / remainder
//   stall_o      : req_valid_i & ~resp_valid_o
// -----------------------------------------------------------------------------
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rs1_data_i,
    input  logic [63:0] rs2_data_i,
    input  logic        rs1_sign_i,
    input  logic        rs2_sign_i,
    input  logic        req_valid_i,
    input  logic        mul_en_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        resp_valid_o,
    output logic [63:0] data_1_o,
    output logic [63:0] data_2_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic        prep_reg;      // first CALC cycle: magnitude conversion
    logic        mul_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic        neg_a_reg;     // effective operand A was negative
    logic        neg_b_reg;     // effective operand B was negative
    logic [63:0] op_a_reg;      // raw operand until prep, magnitude after
    logic [63:0] op_b_reg;
    logic [63:0] acc_hi_reg;    // product high / partial remainder
    logic [63:0] acc_lo_reg;    // multiplier bits / dividend-quotient bits
    logic [63:0] data_1_reg;
    logic [63:0] data_2_reg;

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    logic accept;
    logic div_by_zero;
    logic last_step;

    assign accept      = (state_reg == IDLE) && req_valid_i && !flush_i;
    assign div_by_zero = !mul_en_i && (rs2_data_i == 64'd0);
    assign last_step   = (state_reg == CALC) && !prep_reg && (cnt_reg == 6'd63);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    state_next = div_by_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An abort overrides everything, including an accept in IDLE.
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // Operand magnitudes, computed in the prep cycle from latched operands
    // ---------------------------------------------------------------------
    logic        a_is_neg;
    logic        b_is_neg;
    logic [63:0] mag_a;
    logic [63:0] mag_b;

    assign a_is_neg = sign_a_reg && op_a_reg[63];
    assign b_is_neg = sign_b_reg && op_b_reg[63];
    assign mag_a    = a_is_neg ? (~op_a_reg + 64'd1) : op_a_reg;
    assign mag_b    = b_is_neg ? (~op_b_reg + 64'd1) : op_b_reg;

    // ---------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // ---------------------------------------------------------------------
    logic [64:0] mul_sum;
    logic [64:0] div_shift;
    logic        div_fits;
    logic [63:0] div_diff;
    logic [63:0] step_hi;
    logic [63:0] step_lo;

    always_comb begin
        // Multiply: conditionally add the multiplicand, then shift the
        // {carry, hi, lo} chain right by one.
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, op_a_reg} : 65'd0);

        // Divide: shift the next dividend bit into the partial remainder.
        // The shifted value can need 65 bits. Whenever the subtraction
        // succeeds, the difference is below the divisor, so it fits in
        // 64 bits.
        div_shift = {acc_hi_reg, acc_lo_reg[63]};
        div_fits  = (div_shift >= {1'b0, op_b_reg});
        div_diff  = div_shift[63:0] - op_b_reg;

        if (mul_reg) begin
            step_hi = mul_sum[64:1];
            step_lo = {mul_sum[0], acc_lo_reg[63:1]};
        end else begin
            step_hi = div_fits ? div_diff : div_shift[63:0];
            step_lo = {acc_lo_reg[62:0], div_fits};
        end
    end

    // ---------------------------------------------------------------------
    // Sign correction of the final iteration's result
    // ---------------------------------------------------------------------
    logic [127:0] prod_mag;
    logic [127:0] prod_signed;
    logic [63:0]  quot_signed;
    logic [63:0]  rem_signed;
    logic [63:0]  res_1;
    logic [63:0]  res_2;

    always_comb begin
        prod_mag    = {step_hi, step_lo};
        prod_signed = (neg_a_reg ^ neg_b_reg) ? (~prod_mag + 128'd1) : prod_mag;
        quot_signed = (neg_a_reg ^ neg_b_reg) ? (~step_lo + 64'd1) : step_lo;
        rem_signed  = neg_a_reg ? (~step_hi + 64'd1) : step_hi;
        if (mul_reg) begin
            res_1 = prod_signed[63:0];
            res_2 = prod_signed[127:64];
        end else begin
            res_1 = quot_signed;
            res_2 = rem_signed;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 6'd0;
            prep_reg   <= 1'b0;
            mul_reg    <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            op_a_reg   <= 64'd0;
            op_b_reg   <= 64'd0;
            acc_hi_reg <= 64'd0;
            acc_lo_reg <= 64'd0;
            data_1_reg <= 64'd0;
            data_2_reg <= 64'd0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                op_a_reg   <= rs1_data_i;
                op_b_reg   <= rs2_data_i;
                sign_a_reg <= rs1_sign_i;
                sign_b_reg <= rs2_sign_i;
                mul_reg    <= mul_en_i;
                prep_reg   <= 1'b1;
                cnt_reg    <= 6'd0;
                // Divide by zero skips CALC, so its result is produced here.
                if (div_by_zero) begin
                    data_1_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
                    data_2_reg <= rs1_data_i;
                end
            end

            if ((state_reg == CALC) && !flush_i) begin
                if (prep_reg) begin
                    prep_reg   <= 1'b0;
                    op_a_reg   <= mag_a;
                    op_b_reg   <= mag_b;
                    neg_a_reg  <= a_is_neg;
                    neg_b_reg  <= b_is_neg;
                    acc_hi_reg <= 64'd0;
                    // The multiplier is shifted out of the low word; for
                    // divide, the dividend is shifted out of the same
                    // word while the quotient bits shift in.
                    acc_lo_reg <= mul_reg ? mag_b : mag_a;
                end else begin
                    acc_hi_reg <= step_hi;
                    acc_lo_reg <= step_lo;
                    cnt_reg    <= cnt_reg + 6'd1;
                    if (last_step) begin
                        data_1_reg <= res_1;
                        data_2_reg <= res_2;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ready_o      = (state_reg == IDLE);
    assign resp_valid_o = (state_reg == DONE);
    assign data_1_o     = data_1_reg;
    assign data_2_o     = data_2_reg;
    assign stall_o      = req_valid_i && !resp_valid_o;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Scoreboard bench for muldiv_unit.
//   - The driver issues requests and pushes the expected response, taken
//     from an arithmetic reference model, into a queue. Each entry holds
//     the expected data and the cycle in which the response must appear.
//   - The monitor samples on every falling edge. It pops and compares on
//     resp_valid_o, and flags any response that no entry accounts for.
//   - Between responses the monitor checks that the data outputs hold
//     their last value, and on every cycle it checks stall_o.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        rs1_sign;
    logic        rs2_sign;
    logic        req_valid;
    logic        mul_en;
    logic        flush;
    logic        ready;
    logic        resp_valid;
    logic [63:0] data_1;
    logic [63:0] data_2;
    logic        stall;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .rs1_sign_i   (rs1_sign),
        .rs2_sign_i   (rs2_sign),
        .req_valid_i  (req_valid),
        .mul_en_i     (mul_en),
        .flush_i      (flush),
        .ready_o      (ready),
        .resp_valid_o (resp_valid),
        .data_1_o     (data_1),
        .data_2_o     (data_2),
        .stall_o      (stall)
    );

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [63:0] last_d1 = 64'd0;
    logic [63:0] last_d2 = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the operands are extended to wide signed integers,
    // then ordinary arithmetic is applied and the result truncated.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s1, input logic s2, input logic m,
                                  output logic [63:0] d1, output logic [63:0] d2);
        logic signed [129:0] va;
        logic signed [129:0] vb;
        logic signed [129:0] r;
        va = s1 ? {{66{a[63]}}, a} : {66'd0, a};
        vb = s2 ? {{66{b[63]}}, b} : {66'd0, b};
        if (m) begin
            r  = va * vb;
            d1 = r[63:0];
            d2 = r[127:64];
        end else if (b == 64'd0) begin
            d1 = 64'hFFFF_FFFF_FFFF_FFFF;
            d2 = a;
        end else begin
            r  = va / vb;
            d1 = r[63:0];
            r  = va % vb;
            d2 = r[63:0];
        end
    endfunction

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        check("stall", 64'(stall), 64'(req_valid & ~resp_valid));
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got d1=%h d2=%h required none", data_1, data_2);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp %s: d1=%h d2=%h cycle=%0d", mon_e.name, data_1, data_2, cyc);
                check({mon_e.name, " d1"}, data_1, mon_e.d1);
                check({mon_e.name, " d2"}, data_2, mon_e.d2);
                check({mon_e.name, " latency"}, 64'(cyc), 64'(mon_e.cyc));
            end
            last_d1 = data_1;
            last_d2 = data_2;
        end else begin
            check("hold d1", data_1, last_d1);
            check("hold d2", data_2, last_d2);
        end
    end

    // ---------------------------------------------------------------------
    // Driver. Every task starts and ends 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic issue(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic s1, input logic s2, input logic m, input bit expect_resp);
        exp_t        e;
        logic [63:0] d1;
        logic [63:0] d2;
        rs1_data  = a;
        rs2_data  = b;
        rs1_sign  = s1;
        rs2_sign  = s2;
        mul_en    = m;
        req_valid = 1'b1;
        if (expect_resp) begin
            model(a, b, s1, s2, m, d1, d2);
            e.d1   = d1;
            e.d2   = d2;
            e.cyc  = cyc + ((!m && b == 64'd0) ? 1 : 66);
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Operands change after the accept edge and must be ignored.
        rs1_data  = {$urandom, $urandom};
        rs2_data  = {$urandom, $urandom};
        rs1_sign  = 1'($urandom);
        rs2_sign  = 1'($urandom);
        mul_en    = 1'($urandom);
        check({name, " ready after accept"}, 64'(ready), 64'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check({name, " responses outstanding"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check({name, " ready when idle"}, 64'(ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic        m;
        int          sel;

        rst       = 1'b0;
        rs1_data  = 64'd0;
        rs2_data  = 64'd0;
        rs1_sign  = 1'b0;
        rs2_sign  = 1'b0;
        req_valid = 1'b0;
        mul_en    = 1'b0;
        flush     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset data_1", data_1, 64'd0);
        check("reset data_2", data_2, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        issue("mulu_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        drain("mulu_ones_x2");
        issue("muls_m3_x5", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("muls_m3_x5");
        issue("mulhsu_m1_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("mulhsu_m1_x2");
        issue("divs_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("divs_m7_2");
        issue("divu_7_2", 64'd7, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("divu_7_2");
        issue("div_by_zero", 64'h1234, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("div_by_zero");
        issue("div_overflow", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("div_overflow");

        // Flush in CALC: no response, back to IDLE on the next edge
        issue("flushed_mul", 64'd12345, 64'd678, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("ready after flush", 64'(ready), 64'd1);
        repeat (80) @(posedge clk);
        #1;
        issue("after_flush", 64'hDEAD_BEEF_0000_1111, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("after_flush");

        // Flush beats an accept in the same cycle
        rs1_data  = 64'd99;
        rs2_data  = 64'd0;
        mul_en    = 1'b0;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("ready after flush+req", 64'(ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;

        // Reset in CALC: outputs clear immediately, no response
        issue("reset_mid_calc", 64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async reset ready", 64'(ready), 64'd1);
        check("async reset resp_valid", 64'(resp_valid), 64'd0);
        check("async reset data_1", data_1, 64'd0);
        check("async reset data_2", data_2, 64'd0);
        last_d1 = 64'd0;
        last_d2 = 64'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        issue("after_reset", 64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("after_reset");

        // Random operations, with corner-case operands mixed in
        for (int i = 0; i < 20; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            m   = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: b = 64'd0;
                1: begin
                    a = 64'h8000_0000_0000_0000;
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: a = 64'($urandom_range(0, 1000));
                3: b = 64'($urandom_range(1, 1000));
                default: ;
            endcase
            issue($sformatf("rand%0d", i), a, b, 1'($urandom), 1'($urandom), m, 1'b1);
            drain($sformatf("rand%0d", i));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rs1_data_i, input, 64, operand A (multiplicand or dividend).
REQ-004 SHALL have port rs2_data_i, input, 64, operand B (multiplier or divisor).
REQ-005 SHALL have port rs1_sign_i, input, 1, 1 = operand A is signed.
REQ-006 SHALL have port rs2_sign_i, input, 1, 1 = operand B is signed.
REQ-007 SHALL have port req_valid_i, input, 1, a request is present.
REQ-008 SHALL have port mul_en_i, input, 1, 1 = multiply, 0 = divide.
REQ-009 SHALL have port flush_i, input, 1, aborts any operation in flight.
REQ-010 SHALL have port ready_o, output, 1, unit is in IDLE and can accept a request.
REQ-011 SHALL have port resp_valid_o, output, 1, one-cycle pulse when results are valid.
REQ-012 SHALL have port data_1_o, output, 64, product low half, or quotient.
REQ-013 SHALL have port data_2_o, output, 64, product high half, or remainder.
REQ-014 SHALL have port stall_o, output, 1, equal to req_valid_i & ~resp_valid_o; holds the pipeline.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL accept a request only in IDLE with req_valid_i=1, and SHALL latch operands, signs and mul_en_i on that edge.
REQ-017 SHALL go IDLE->CALC on accept, except a divide with rs2=0, which SHALL go IDLE->DONE.
REQ-018 SHALL run CALC for exactly 64 cycles using a 6-bit counter, one bit per cycle, then go to DONE.
REQ-019 SHALL hold resp_valid_o=1 for the single DONE cycle, then go DONE->IDLE unconditionally.
REQ-020 SHALL keep data_1_o/data_2_o stable from DONE until the next DONE.
REQ-021 SHALL give a latency of 66 cycles from the accept edge to resp_valid_o (1 prep cycle, 64 CALC cycles, 1 DONE cycle), and 1 cycle for divide-by-zero.
REQ-022 SHALL, for a signed operand, use its magnitude internally (two's-complement negate when bit 63=1), and SHALL form an unsigned 128-bit shift-add product or a restoring-division quotient and remainder.
REQ-023 SHALL negate the 128-bit product on output when exactly one effective operand is negative.
REQ-024 SHALL negate the quotient when the dividend and divisor signs differ, and SHALL give the remainder the sign of the dividend.
REQ-025 SHALL, on divide by zero, produce quotient 64'hFFFF_FFFF_FFFF_FFFF and remainder equal to the dividend, regardless of the sign inputs.
REQ-026 SHALL, on signed overflow (8000_0000_0000_0000 / -1), produce quotient equal to the dividend and remainder 0, with no exception.
REQ-027 SHALL, when flush_i=1, go to IDLE on the next edge from any state with no resp_valid_o pulse; flush_i SHALL win over an accept in the same cycle.
REQ-028 SHALL have the requester present a new request, or deassert req_valid_i, in the cycle after resp_valid_o, because IDLE treats any asserted req_valid_i as a new request.
REQ-029 SHALL ignore req_valid_i in CALC and DONE, and SHALL ignore operand changes during CALC.
REQ-030 SHALL use 64-bit operations only; any 32-bit word-form truncation and sign-extension is done by the requester.

Reset
REQ-031 SHALL, while rst=0, go to IDLE immediately with counter=0, resp_valid_o=0, data_1_o=0 and data_2_o=0; ready_o SHALL be 1 during reset.
REQ-032 SHALL, on reset during CALC, discard the partial result with no response pulse.
REQ-033 SHALL leave IDLE no earlier than the first rising edge after rst deasserts.

Verification
REQ-034 SHALL be verified with: unsigned mul, A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> data_1=0xFFFF_FFFF_FFFF_FFFE, data_2=1, resp_valid 66 cycles after accept.
REQ-035 SHALL be verified with: signed mul, A=-3, B=5 -> data_1=0xFFFF_FFFF_FFFF_FFF1, data_2=0xFFFF_FFFF_FFFF_FFFF; and mulhsu, A=-1, B=2 (rs2 unsigned) -> data_2=0xFFFF_FFFF_FFFF_FFFF.
REQ-036 SHALL be verified with: signed div, A=-7, B=2 -> quotient -3, remainder -1; unsigned div, A=7, B=2 -> quotient 3, remainder 1.
REQ-037 SHALL be verified with: div by zero, A=0x1234 -> quotient all ones, remainder 0x1234, resp_valid the cycle after accept; and signed div 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-038 SHALL be verified with: flush_i asserted in CALC cycle 30 -> IDLE next cycle, no resp_valid; a new request is then accepted and completes correctly.
REQ-039 SHALL be verified with: rst pulled low in CALC cycle 10 -> outputs 0 and ready_o=1 immediately; stall_o tracks req_valid_i & ~resp_valid_o throughout.
